// File: rtl/gtf_raw_prbs_tx_gen.sv
// PRBS word source for the GTF raw-mode TX path: unrolled ITU-T O.150 LFSR with a
// valid/ready output, single-bit error injection, seed reload and word/error counters.
module gtf_raw_prbs_tx_gen #(
  parameter int          DATA_WIDTH = 64,
  parameter int          PRBS_ORDER = 31,
  parameter logic [30:0] PRBS_SEED  = 31'h7FFF_FFFF
) (
  input  logic                  gtwiz_userclk_tx_usrclk2_in,
  input  logic                  gtwiz_reset_tx_n_in,
  input  logic                  enable_in,
  input  logic                  tx_ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  input  logic                  err_inject_in,
  input  logic                  seed_load_in,
  input  logic [30:0]           seed_in,
  output logic                  running_out,
  output logic [47:0]           word_count_out,
  output logic [15:0]           err_count_out
);

  localparam int N   = PRBS_ORDER;
  localparam int TAP = (N == 7)  ? 6  :
                       (N == 9)  ? 5  :
                       (N == 15) ? 14 :
                       (N == 23) ? 18 : 28;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                state, state_nxt;
  logic [N-1:0]          lfsr, lfsr_base, lfsr_adv;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  load, accept, valid_nxt, inject_pending;

  // An all-zero LFSR would lock up, so it is replaced by all ones.
  function automatic logic [N-1:0] fix_seed(input logic [N-1:0] s);
    return (s == '0) ? '1 : s;
  endfunction

  function automatic logic [DATA_WIDTH+N-1:0] prbs_word(input logic [N-1:0] s_in);
    logic [N-1:0]          s;
    logic [DATA_WIDTH-1:0] w;
    logic                  b;
    s = s_in;
    w = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      b    = s[N-1] ^ s[TAP-1];
      w[i] = b;
      s    = {s[N-2:0], b};
    end
    return {s, w};
  endfunction

  // A seed load in IDLE takes effect before a coincident first-word computation.
  always_comb begin
    lfsr_base = lfsr;
    if (state == IDLE && seed_load_in)
      lfsr_base = fix_seed(seed_in[N-1:0]);
    {lfsr_adv, word_nxt} = prbs_word(lfsr_base);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    valid_nxt = data_valid_out;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (enable_in) begin
          load      = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        accept = data_valid_out & tx_ready_in;
        if (enable_in) begin
          load = accept;
        end else if (accept) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tx_ready_in) begin
          accept    = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gtwiz_userclk_tx_usrclk2_in or negedge gtwiz_reset_tx_n_in) begin
    if (!gtwiz_reset_tx_n_in) begin
      state          <= IDLE;
      lfsr           <= fix_seed(PRBS_SEED[N-1:0]);
      data_out       <= '0;
      data_valid_out <= 1'b0;
      inject_pending <= 1'b0;
      word_count_out <= '0;
      err_count_out  <= '0;
    end else begin
      state          <= state_nxt;
      data_valid_out <= valid_nxt;
      lfsr           <= load ? lfsr_adv : lfsr_base;
      if (load)
        data_out <= word_nxt ^ {{(DATA_WIDTH-1){1'b0}}, inject_pending};
      // A pulse coincident with a load re-arms injection for the following word.
      inject_pending <= err_inject_in | (inject_pending & ~load);
      if (load && inject_pending && err_count_out != 16'hFFFF)
        err_count_out <= err_count_out + 16'd1;
      if (accept)
        word_count_out <= word_count_out + 48'd1;
    end
  end

  assign running_out = (state != IDLE);

endmodule

// File: tb/tb_gtf_raw_prbs_tx_gen.sv
// Directed bench for gtf_raw_prbs_tx_gen in a PRBS7 / 16-bit configuration, compared
// against a bit-serial PRBS7 reference and hand-computed words.
module tb_gtf_raw_prbs_tx_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, ready, err_inj, seed_load;
  logic [30:0] seed;
  logic [15:0] data;
  logic        valid, running;
  logic [47:0] wcnt;
  logic [15:0] ecnt;

  int          checks = 0;
  int          errors = 0;
  logic [6:0]  ms;
  logic [15:0] exp_w, w0;
  logic [47:0] exp_cnt;
  logic        acc;

  always #5 clk = ~clk;

  gtf_raw_prbs_tx_gen #(
    .DATA_WIDTH(16),
    .PRBS_ORDER(7),
    .PRBS_SEED (31'h7F)
  ) dut (
    .gtwiz_userclk_tx_usrclk2_in(clk),
    .gtwiz_reset_tx_n_in        (rst_n),
    .enable_in                  (enable),
    .tx_ready_in                (ready),
    .data_out                   (data),
    .data_valid_out             (valid),
    .err_inject_in              (err_inj),
    .seed_load_in               (seed_load),
    .seed_in                    (seed),
    .running_out                (running),
    .word_count_out             (wcnt),
    .err_count_out              (ecnt)
  );

  task automatic model_word(output logic [15:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b    = ms[6] ^ ms[5];
      w[i] = b;
      ms   = {ms[5:0], b};
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; ready = 1'b0; err_inj = 1'b0;
    seed_load = 1'b0; seed = '0; exp_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_running", running, 0);
    chk("rst_wcnt", wcnt, 0);
    chk("rst_ecnt", ecnt, 0);
    rst_n = 1'b1;

    // Continuous stream with ready tied high
    ms = 7'h7F;
    enable = 1'b1; ready = 1'b1;
    tick;
    model_word(exp_w);
    w0 = exp_w;
    chk("first_word_hand", data, 16'h3040);
    chk("first_word_model", data, exp_w);
    chk("first_valid", valid, 1);
    chk("first_running", running, 1);
    for (int i = 1; i <= 254; i++) begin
      tick;
      model_word(exp_w);
      chk("prbs7_stream", data, exp_w);
      if (i == 127) chk("period_127", data, w0);
    end
    chk("wcnt_254", wcnt, 254);
    enable = 1'b0;
    tick;
    exp_cnt = 48'd255;
    chk("idle_valid", valid, 0);
    chk("idle_running", running, 0);
    chk("wcnt_255", wcnt, exp_cnt);

    // Random stalls, sequence continues across the idle gap
    ready = 1'b0; enable = 1'b1;
    tick;
    model_word(exp_w);
    chk("reenable_word", data, exp_w);
    chk("reenable_valid", valid, 1);
    for (int i = 0; i < 150; i++) begin
      acc = 1'($urandom_range(0, 1));
      ready = acc;
      tick;
      if (acc) begin
        model_word(exp_w);
        exp_cnt++;
      end
      chk("stall_stream", data, exp_w);
      chk("stall_valid", valid, 1);
    end
    chk("stall_wcnt", wcnt, exp_cnt);

    // Enable drop while stalled: STOP holds, then IDLE
    ready = 1'b0; enable = 1'b0;
    tick;
    chk("stop_running", running, 1);
    chk("stop_valid", valid, 1);
    chk("stop_data", data, exp_w);
    tick;
    chk("stop_hold", data, exp_w);
    enable = 1'b1;
    tick;
    chk("stop_ignore_en", running, 1);
    chk("stop_hold2", data, exp_w);
    ready = 1'b1;
    tick;
    exp_cnt++;
    chk("stop_exit_valid", valid, 0);
    chk("stop_exit_running", running, 0);
    chk("stop_exit_wcnt", wcnt, exp_cnt);
    tick;
    model_word(exp_w);
    chk("after_stop_word", data, exp_w);
    chk("after_stop_valid", valid, 1);

    // Error injection: three pulses during a stall collapse into one
    ready = 1'b0; err_inj = 1'b1;
    tick; tick; tick;
    err_inj = 1'b0;
    chk("inj_pending_ecnt", ecnt, 0);
    chk("inj_stall_hold", data, exp_w);
    ready = 1'b1;
    tick;
    exp_cnt++;
    model_word(exp_w);
    chk("inj_word1", data, exp_w ^ 16'h0001);
    chk("inj_ecnt1", ecnt, 1);
    tick;
    exp_cnt++;
    model_word(exp_w);
    chk("inj_clean1", data, exp_w);
    err_inj = 1'b1;
    tick;
    err_inj = 1'b0;
    exp_cnt++;
    model_word(exp_w);
    chk("inj_coincident_clean", data, exp_w);
    tick;
    exp_cnt++;
    model_word(exp_w);
    chk("inj_word2", data, exp_w ^ 16'h0001);
    chk("inj_ecnt2", ecnt, 2);
    tick;
    exp_cnt++;
    model_word(exp_w);
    chk("inj_clean2", data, exp_w);
    chk("inj_ecnt_final", ecnt, 2);
    chk("inj_wcnt", wcnt, exp_cnt);

    // Seed load: zero in IDLE, ignored in RUN, coincident with enable
    enable = 1'b0;
    tick;
    exp_cnt++;
    chk("seed_idle_valid", valid, 0);
    seed = '0; seed_load = 1'b1;
    tick;
    seed_load = 1'b0; enable = 1'b1;
    tick;
    ms = 7'h7F;
    model_word(exp_w);
    chk("seed_zero_hand", data, 16'h3040);
    chk("seed_zero_model", data, exp_w);
    seed = 31'h55; seed_load = 1'b1;
    tick;
    seed_load = 1'b0;
    exp_cnt++;
    model_word(exp_w);
    chk("seed_run_ignored", data, exp_w);
    tick;
    exp_cnt++;
    model_word(exp_w);
    chk("seed_run_cont", data, exp_w);
    enable = 1'b0;
    tick;
    exp_cnt++;
    seed = 31'h01; seed_load = 1'b1; enable = 1'b1;
    tick;
    seed_load = 1'b0;
    ms = 7'h01;
    model_word(exp_w);
    chk("seed_with_enable", data, exp_w);
    chk("seed_wcnt", wcnt, exp_cnt);

    // Asynchronous reset in RUN
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", valid, 0);
    chk("async_rst_data", data, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_wcnt", wcnt, 0);
    chk("async_rst_ecnt", ecnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    ms = 7'h7F;
    model_word(exp_w);
    chk("post_rst_hand", data, 16'h3040);
    chk("post_rst_model", data, exp_w);
    chk("post_rst_valid", valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
